// File: rtl/video_pkg.sv
// Shared types and constants for the video source selector: RGB444 geometry,
// selector FSM states and a channel-slice helper.
package video_pkg;

    localparam int RGB_CHAN_W  = 4;
    localparam int COLOR_W_DEF = 3 * RGB_CHAN_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_FADING
    } mux_state_t;

    function automatic logic [RGB_CHAN_W-1:0] rgb_channel(
        input logic [COLOR_W_DEF-1:0] color,
        input int unsigned            idx
    );
        return color[idx*RGB_CHAN_W +: RGB_CHAN_W];
    endfunction

endpackage

// File: rtl/color_lerp.sv
// Combinational linear blend of one colour channel: (a*(S-k) + b*k) >> FADE_LOG2.
// With k=0 the result is exactly a; the shift truncates.
module color_lerp
    import video_pkg::*;
#(
    parameter int CW        = RGB_CHAN_W,
    parameter int FADE_LOG2 = 4
) (
    input  logic [CW-1:0]        a,
    input  logic [CW-1:0]        b,
    input  logic [FADE_LOG2-1:0] k,
    output logic [CW-1:0]        y
);

    localparam int                 PW    = CW + FADE_LOG2 + 1;
    localparam logic [FADE_LOG2:0] SCALE = {1'b1, {FADE_LOG2{1'b0}}};

    logic [FADE_LOG2:0] w_nxt;
    logic [FADE_LOG2:0] w_cur;
    logic [PW-1:0]      sum;

    always_comb begin
        w_nxt = {1'b0, k};
        w_cur = SCALE - w_nxt;
        sum   = PW'(a) * PW'(w_cur) + PW'(b) * PW'(w_nxt);
        y     = CW'(sum >> FADE_LOG2);
    end

endmodule

// File: rtl/video_source_mux.sv
// Frame-synchronous N-input pixel source selector with optional crossfade.
// Two-stage pipeline: stage 1 picks current/next pixels, stage 2 blends them.
module video_source_mux
    import video_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int COLOR_W   = COLOR_W_DEF,
    parameter int FADE_LOG2 = 4,
    parameter int SEL_W     = $clog2(NUM_SRC)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC*COLOR_W-1:0] src_color,
    input  logic                       de,
    input  logic                       frame_start,
    input  logic [SEL_W-1:0]           select,
    input  logic                       fade_en,
    output logic [COLOR_W-1:0]         vga_color,
    output logic                       de_o,
    output logic [SEL_W-1:0]           active_sel,
    output logic                       busy
);

    localparam int                   CW        = COLOR_W / 3;
    localparam logic [SEL_W:0]       SRC_LIMIT = (SEL_W+1)'(NUM_SRC);
    localparam logic [FADE_LOG2-1:0] K_LAST    = '1;
    localparam logic [FADE_LOG2-1:0] K_ONE     = FADE_LOG2'(1);

    mux_state_t           state, state_nxt;
    logic [SEL_W-1:0]     next_sel, next_sel_nxt, active_sel_nxt, target;
    logic [FADE_LOG2-1:0] k, k_nxt;
    logic                 sel_valid;

    logic [COLOR_W-1:0]   src_arr [NUM_SRC];
    logic [COLOR_W-1:0]   cur_px, nxt_px, blend_px;
    logic                 de_s1;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_arr[i] = src_color[i*COLOR_W +: COLOR_W];
    end

    assign sel_valid = {1'b0, select} < SRC_LIMIT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            active_sel <= '0;
            next_sel   <= '0;
            k          <= '0;
        end else begin
            state      <= state_nxt;
            active_sel <= active_sel_nxt;
            next_sel   <= next_sel_nxt;
            k          <= k_nxt;
        end
    end

    // A pending request follows select until the frame boundary; once fading, the target is frozen.
    always_comb begin
        state_nxt      = state;
        next_sel_nxt   = next_sel;
        active_sel_nxt = active_sel;
        k_nxt          = k;
        target         = next_sel;
        case (state)
            ST_IDLE: begin
                if (sel_valid && (select != active_sel)) begin
                    state_nxt    = ST_PENDING;
                    next_sel_nxt = select;
                end
            end
            ST_PENDING: begin
                if (sel_valid) target = select;
                if (select == active_sel) begin
                    state_nxt = ST_IDLE;
                end else begin
                    next_sel_nxt = target;
                    if (frame_start) begin
                        if (fade_en) begin
                            state_nxt = ST_FADING;
                            k_nxt     = K_ONE;
                        end else begin
                            active_sel_nxt = target;
                            state_nxt      = ST_IDLE;
                        end
                    end
                end
            end
            ST_FADING: begin
                if (frame_start) begin
                    if (k == K_LAST) begin
                        active_sel_nxt = next_sel;
                        k_nxt          = '0;
                        state_nxt      = ST_IDLE;
                    end else begin
                        k_nxt = k + K_ONE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

    for (genvar c = 0; c < 3; c++) begin : g_lerp
        color_lerp #(
            .CW       (CW),
            .FADE_LOG2(FADE_LOG2)
        ) u_lerp (
            .a(cur_px[c*CW +: CW]),
            .b(nxt_px[c*CW +: CW]),
            .k(k),
            .y(blend_px[c*CW +: CW])
        );
    end

    // Blanking forces black so downstream never sees stale pixels outside active video.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_px    <= '0;
            nxt_px    <= '0;
            de_s1     <= 1'b0;
            vga_color <= '0;
            de_o      <= 1'b0;
        end else begin
            cur_px    <= src_arr[active_sel];
            nxt_px    <= src_arr[next_sel];
            de_s1     <= de;
            de_o      <= de_s1;
            vga_color <= de_s1 ? blend_px : '0;
        end
    end

endmodule
